// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped TX/RX FIFOs and status register on the LSB bus.
// Optional internal TX->RX loopback selected by defining MEM_IO_LOOPBACK_EN.
module mem_io_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h0003_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_addr,
  input  logic        ram_writing,
  input  logic [7:0]  ram_data,
  output logic [7:0]  ram_loaded_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        io_full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HINT_CNT = CW'(FIFO_DEPTH - 2);

  logic [7:0] mem    [2**ADDR_WIDTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          ovf_q, ovf_d;
  logic          prev_hit_data_q, prev_hit_data_d;
  logic          prev_hit_stat_q, prev_hit_stat_d;
  logic [7:0]    ram_loaded_data_q, ram_loaded_data_d;

  logic                  hit_data, hit_stat, is_ram;
  logic                  data_first, stat_first;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  tx_full, tx_nonempty, rx_full, rx_nonempty;
  logic                  tx_push, tx_pop, tx_accept, rx_push, rx_pop;
  logic [7:0]            tx_head, rx_head, rx_push_data, status;

  always_comb begin
    hit_data    = (ram_addr == IO_BASE);
    hit_stat    = (ram_addr == IO_BASE + 32'd4);
    is_ram      = !hit_data && !hit_stat;
    ram_idx     = ram_addr[ADDR_WIDTH-1:0];
    data_first  = !ram_writing && hit_data && !prev_hit_data_q;
    stat_first  = !ram_writing && hit_stat && !prev_hit_stat_q;
    tx_full     = (tx_cnt_q == FULL_CNT);
    tx_nonempty = (tx_cnt_q != '0);
    rx_full     = (rx_cnt_q == FULL_CNT);
    rx_nonempty = (rx_cnt_q != '0);
    tx_head     = tx_mem[tx_rd_q];
    rx_head     = rx_mem[rx_rd_q];
    status      = {5'b0, ovf_q, tx_full, rx_nonempty};
  end

`ifdef MEM_IO_LOOPBACK_EN
  logic lb_unused;
  assign lb_unused    = ^{tx_ready, rx_valid, rx_data};
  assign tx_valid     = 1'b0;
  assign rx_ready     = 1'b0;
  assign tx_pop       = tx_nonempty && !rx_full;
  assign rx_push      = tx_pop;
  assign rx_push_data = tx_head;
`else
  assign tx_valid     = tx_nonempty;
  assign rx_ready     = !rx_full;
  assign tx_pop       = tx_nonempty && tx_ready;
  assign rx_push      = rx_valid && !rx_full;
  assign rx_push_data = rx_data;
`endif

  assign tx_data         = tx_nonempty ? tx_head : 8'h00;
  assign io_full         = (tx_cnt_q >= HINT_CNT);
  assign ram_loaded_data = ram_loaded_data_q;

  // A full TX FIFO still takes a push when the head leaves on the same edge.
  always_comb begin
    tx_push   = ram_writing && hit_data;
    tx_accept = tx_push && (!tx_full || tx_pop);
    rx_pop    = data_first && rx_nonempty;
    tx_wr_d   = tx_wr_q + PW'(tx_accept);
    tx_rd_d   = tx_rd_q + PW'(tx_pop);
    tx_cnt_d  = tx_cnt_q + CW'(tx_accept) - CW'(tx_pop);
    rx_wr_d   = rx_wr_q + PW'(rx_push);
    rx_rd_d   = rx_rd_q + PW'(rx_pop);
    rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    ovf_d     = ovf_q;
    if (tx_push && !tx_accept) begin
      ovf_d = 1'b1;
    end else if (stat_first) begin
      ovf_d = 1'b0;
    end
    prev_hit_data_d = hit_data && !ram_writing;
    prev_hit_stat_d = hit_stat && !ram_writing;
  end

  // Held IO-data address keeps the byte returned on its first cycle.
  always_comb begin
    ram_loaded_data_d = ram_loaded_data_q;
    if (!ram_writing) begin
      if (hit_data) begin
        if (!prev_hit_data_q) begin
          ram_loaded_data_d = rx_nonempty ? rx_head : 8'h00;
        end
      end else if (hit_stat) begin
        ram_loaded_data_d = status;
      end else begin
        ram_loaded_data_d = mem[ram_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_writing && is_ram) mem[ram_idx] <= ram_data;
    if (tx_accept)             tx_mem[tx_wr_q] <= ram_data;
    if (rx_push)               rx_mem[rx_wr_q] <= rx_push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_q           <= '0;
      tx_rd_q           <= '0;
      tx_cnt_q          <= '0;
      rx_wr_q           <= '0;
      rx_rd_q           <= '0;
      rx_cnt_q          <= '0;
      ovf_q             <= 1'b0;
      prev_hit_data_q   <= 1'b0;
      prev_hit_stat_q   <= 1'b0;
      ram_loaded_data_q <= 8'h00;
    end else begin
      tx_wr_q           <= tx_wr_d;
      tx_rd_q           <= tx_rd_d;
      tx_cnt_q          <= tx_cnt_d;
      rx_wr_q           <= rx_wr_d;
      rx_rd_q           <= rx_rd_d;
      rx_cnt_q          <= rx_cnt_d;
      ovf_q             <= ovf_d;
      prev_hit_data_q   <= prev_hit_data_d;
      prev_hit_stat_q   <= prev_hit_stat_d;
      ram_loaded_data_q <= ram_loaded_data_d;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized + directed bench for mem_io_responder against a queue-based reference model.
module tb_mem_io_responder;
  localparam int          AW  = 17;
  localparam int          D   = 8;
  localparam logic [31:0] IOB = 32'h0003_0000;
  localparam logic [31:0] IOS = IOB + 32'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ram_addr;
  logic        ram_writing;
  logic [7:0]  ram_data, ram_loaded_data, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, io_full;

  always #5 clk = ~clk;

  mem_io_responder #(.ADDR_WIDTH(AW), .IO_BASE(IOB), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_writing(ram_writing),
    .ram_data(ram_data), .ram_loaded_data(ram_loaded_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .io_full(io_full)
  );

  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] m_mem[int];
  logic       m_ovf, m_prev_d, m_prev_s, m_ld_known;
  logic [7:0] m_ld;
  int n_vec = 0, n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_ovf = 1'b0;
    m_prev_d = 1'b0;
    m_prev_s = 1'b0;
    m_ld = 8'h00;
    m_ld_known = 1'b1;
  endtask

  task automatic model_step(input logic [31:0] a, input logic w, input logic [7:0] d,
                            input logic tr, input logic rv, input logic [7:0] rd);
    bit hd, hs, tx_pop, rx_push;
    int txn, rxn, idx;
    logic [7:0] st, pushv;
    hd  = (a == IOB);
    hs  = (a == IOS);
    txn = m_tx.size();
    rxn = m_rx.size();
    idx = int'(a[AW-1:0]);
    st  = {5'b0, m_ovf, (txn == D), (rxn != 0)};
`ifdef MEM_IO_LOOPBACK_EN
    tx_pop  = (txn != 0) && (rxn != D);
    rx_push = tx_pop;
    pushv   = tx_pop ? m_tx[0] : 8'h00;
`else
    tx_pop  = (txn != 0) && tr;
    rx_push = rv && (rxn != D);
    pushv   = rd;
`endif
    if (!w) begin
      if (hd) begin
        if (!m_prev_d) begin
          m_ld = (rxn != 0) ? m_rx[0] : 8'h00;
          m_ld_known = 1'b1;
          if (rxn != 0) void'(m_rx.pop_front());
        end
      end else if (hs) begin
        m_ld = st;
        m_ld_known = 1'b1;
        if (!m_prev_s) m_ovf = 1'b0;
      end else if (m_mem.exists(idx)) begin
        m_ld = m_mem[idx];
        m_ld_known = 1'b1;
      end else begin
        m_ld_known = 1'b0;
      end
    end
    if (tx_pop) void'(m_tx.pop_front());
    if (w && hd) begin
      if (txn < D || tx_pop) m_tx.push_back(d);
      else m_ovf = 1'b1;
    end
    if (w && !hd && !hs) m_mem[idx] = d;
    if (rx_push) m_rx.push_back(pushv);
    m_prev_d = hd && !w;
    m_prev_s = hs && !w;
  endtask

  task automatic compare_all();
    logic [7:0] exp_td;
    exp_td = (m_tx.size() != 0) ? m_tx[0] : 8'h00;
`ifdef MEM_IO_LOOPBACK_EN
    chk("tx_valid", 32'(tx_valid), 32'(0));
    chk("rx_ready", 32'(rx_ready), 32'(0));
`else
    chk("tx_valid", 32'(tx_valid), 32'(m_tx.size() != 0));
    chk("rx_ready", 32'(rx_ready), 32'(m_rx.size() != D));
`endif
    chk("tx_data", 32'(tx_data), 32'(exp_td));
    chk("io_full", 32'(io_full), 32'(m_tx.size() >= D - 2));
    if (m_ld_known) chk("ram_loaded_data", 32'(ram_loaded_data), 32'(m_ld));
  endtask

  task automatic cyc(input logic [31:0] a, input logic w, input logic [7:0] d,
                     input logic tr, input logic rv, input logic [7:0] rd);
    ram_addr = a; ram_writing = w; ram_data = d;
    tx_ready = tr; rx_valid = rv; rx_data = rd;
    model_step(a, w, d, tr, rv, rd);
    @(posedge clk);
    #1;
    n_vec++;
    compare_all();
  endtask

  initial begin
    logic [31:0] a, prev_a;
    rst = 1'b0;
    ram_addr = 32'h100; ram_writing = 1'b0; ram_data = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset tx_valid", 32'(tx_valid), 32'(0));
    chk("reset tx_data", 32'(tx_data), 32'(0));
    chk("reset io_full", 32'(io_full), 32'(0));
    chk("reset loaded", 32'(ram_loaded_data), 32'(0));
`ifndef MEM_IO_LOOPBACK_EN
    chk("reset rx_ready", 32'(rx_ready), 32'(1));
`endif
    rst = 1'b1;

    cyc(32'h00100, 1, 8'hA5, 0, 0, 0);
    cyc(32'h00100, 0, 8'h00, 0, 0, 0);
    chk("ram read A5", 32'(ram_loaded_data), 32'hA5);
    cyc(32'h20100, 1, 8'h3C, 0, 0, 0);
    cyc(32'h00100, 0, 8'h00, 0, 0, 0);
    chk("ram alias 3C", 32'(ram_loaded_data), 32'h3C);

`ifndef MEM_IO_LOOPBACK_EN
    for (int i = 1; i <= 9; i++) begin
      cyc(IOB, 1, 8'(i), 0, 0, 0);
      if (i == 5) chk("io_full after 5", 32'(io_full), 32'(0));
      if (i == 6) chk("io_full after 6", 32'(io_full), 32'(1));
    end
    cyc(IOS, 0, 8'h00, 0, 0, 0);
    chk("status ovf+full", 32'(ram_loaded_data), 32'h06);
    cyc(32'h00100, 0, 8'h00, 0, 0, 0);
    cyc(IOS, 0, 8'h00, 0, 0, 0);
    chk("status after clear", 32'(ram_loaded_data), 32'h02);
    for (int i = 1; i <= 8; i++) begin
      chk("tx drain order", 32'(tx_data), 32'(i));
      cyc(32'h00100, 0, 8'h00, 1, 0, 0);
    end
    chk("tx empty after drain", 32'(tx_valid), 32'(0));

    cyc(32'h00100, 0, 8'h00, 0, 1, 8'h41);
    cyc(32'h00100, 0, 8'h00, 0, 1, 8'h42);
    for (int i = 0; i < 4; i++) begin
      cyc(IOB, 0, 8'h00, 0, 0, 0);
      chk("rx held read", 32'(ram_loaded_data), 32'h41);
    end
    cyc(32'h00100, 0, 8'h00, 0, 0, 0);
    cyc(IOB, 0, 8'h00, 0, 0, 0);
    chk("rx second byte", 32'(ram_loaded_data), 32'h42);
    cyc(32'h00100, 0, 8'h00, 0, 0, 0);
    cyc(IOB, 0, 8'h00, 0, 0, 0);
    chk("rx empty read", 32'(ram_loaded_data), 32'h00);

    for (int i = 0; i < 8; i++) cyc(IOB, 1, 8'h60 + 8'(i), 0, 0, 0);
    cyc(IOB, 1, 8'hEE, 1, 0, 0);
    cyc(IOS, 0, 8'h00, 0, 0, 0);
    chk("full push+pop no ovf", 32'(ram_loaded_data), 32'h02);
    for (int i = 0; i < 20; i++) cyc(IOB, 1, 8'h80 + 8'(i), 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(32'h00100, 0, 8'h00, 1, 0, 0);
    chk("wrap drained", 32'(tx_valid), 32'(0));

    for (int i = 0; i < 3; i++) cyc(IOB, 1, 8'hC0 + 8'(i), 0, 0, 0);
    ram_addr = 32'h100; ram_writing = 1'b0;
    #3 rst = 1'b0;
    #1 chk("async reset tx_valid", 32'(tx_valid), 32'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc(IOS, 0, 8'h00, 0, 0, 0);
    chk("status after reset", 32'(ram_loaded_data), 32'h00);
`else
    cyc(IOB, 1, 8'h5A, 0, 0, 0);
    cyc(32'h00100, 0, 8'h00, 0, 0, 0);
    cyc(32'h00100, 0, 8'h00, 0, 0, 0);
    cyc(IOB, 0, 8'h00, 0, 0, 0);
    chk("loopback read", 32'(ram_loaded_data), 32'h5A);
`endif

    prev_a = 32'h100;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: a = IOB;
        3:       a = IOS;
        4:       a = prev_a;
        default: a = 32'h100 + 32'($urandom_range(0, 15)) + ($urandom_range(0, 1) ? 32'h20000 : 32'h0);
      endcase
      cyc(a, ($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      prev_a = a;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target (responder) side of the byte-wide RAM bus that the load/store unit drives: `ram_addr`, `ram_writing`, `ram_data` in; `ram_loaded_data` out.
- Contains the on-chip byte RAM with a registered one-cycle read.
- Decodes a small memory-mapped IO window:
  - TX FIFO toward the serial transmitter.
  - RX FIFO from the serial receiver.
  - Status byte.
- Sits between the LSB bus and the board-level serial link.

Parameters:
- ADDR_WIDTH, 17: RAM byte-address width; RAM depth is 2^ADDR_WIDTH bytes.
- IO_BASE, 32'h00030000: base of the IO window. IO_BASE+0 is the data register; IO_BASE+4 is the status register.
- FIFO_DEPTH, 8: entries per FIFO; must be a power of 2, at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ram_addr  in  32  byte address from the LSB.
- ram_writing  in  1  1 = write `ram_data` at `ram_addr` this cycle.
- ram_data  in  8  write byte.
- ram_loaded_data  out  8  registered read byte for the address sampled at the previous rising edge.
- tx_data  out  8  head of the TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  transmitter accepts `tx_data` when `tx_valid` && `tx_ready`.
- rx_data  in  8  received byte.
- rx_valid  in  1  received byte offered.
- rx_ready  out  1  RX FIFO not full; a byte is accepted when `rx_valid` && `rx_ready`.
- io_full  out  1  TX FIFO occupancy >= FIFO_DEPTH-2 (early back-pressure hint).

Behaviour:
- Reset (`rst`=0, asynchronous):
  - `ram_loaded_data`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=1, `io_full`=0.
  - Both FIFOs empty, pointers 0, overflow flag 0, prev_hit_data 0.
  - RAM contents are not reset.
  - Reset mid-transfer discards all queued bytes. The first edge after release behaves as from idle.
- Decode:
  - hit_data = (`ram_addr` == IO_BASE).
  - hit_stat = (`ram_addr` == IO_BASE+4).
  - Any other address is RAM at `ram_addr[ADDR_WIDTH-1:0]`; upper bits are ignored, aliasing permitted.
- RAM write: `ram_writing`=1 and RAM address: byte stored at the edge.
- RAM read: `ram_writing`=0: `ram_loaded_data` <= mem[addr] at the edge, giving 1-cycle latency.
- Write while `ram_writing`=1: `ram_loaded_data` holds its previous value.
- Read-during-write to the same address is not possible, since the bus is single-ported per cycle.
- IO data write (`ram_writing`=1, hit_data):
  - Pushes `ram_data` into the TX FIFO.
  - If the TX FIFO is full and no pop happens this edge, the byte is dropped and the sticky overflow flag is set.
- IO data read (`ram_writing`=0, hit_data):
  - `ram_loaded_data` <= RX head.
  - The RX FIFO pops only when prev_hit_data=0, i.e. on the first cycle of a held address. This covers the LSB leaving the address on the bus across idle cycles.
  - Reading an empty RX FIFO returns 8'h00 with no pop.
- prev_hit_data <= hit_data && !`ram_writing` every edge.
- Status read (hit_stat):
  - `ram_loaded_data` <= {5'b0, overflow, tx_full, rx_nonempty}.
  - On the first cycle of the hit, overflow is cleared, using the same edge rule as the data pop.
  - Writes to the status register are ignored.
- FIFOs:
  - Circular; read/write pointers of log2(FIFO_DEPTH) bits wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop in one edge: both happen, count unchanged. This holds even when full, so a full FIFO with a concurrent pop accepts the push.
  - Simultaneous pop and push when empty: the push is stored and the pop has no effect.
- TX drain:
  - On `tx_valid` && `tx_ready`, the head is popped.
  - `tx_data`/`tx_valid` reflect the new head after the edge. `tx_data` is combinational from the head entry.
- RX fill: on `rx_valid` && `rx_ready`, `rx_data` is pushed.
- `rx_ready` = RX count != FIFO_DEPTH; `io_full` is derived from the registered count.

Optional Feature:
- Macro MEM_IO_LOOPBACK_EN.
- When defined:
  - The TX FIFO head feeds the RX FIFO internally; a transfer occurs when TX is non-empty and RX is not full.
  - `tx_valid` is tied 0; `tx_ready`, `rx_valid` and `rx_data` are ignored.
  - `rx_ready` is tied 0.
- When undefined: external ports behave as described above.

Test Plan:
- Write 8'hA5 at 0x00100, then read 0x00100 → `ram_loaded_data`=8'hA5 one edge after the read address is sampled. A write to 0x20100 aliases to 0x00100 when ADDR_WIDTH=17.
- Push 9 bytes 0x01..0x09 to IO_BASE with `tx_ready`=0:
  - `io_full`=1 after the 6th byte.
  - Status read returns 8'h06 (overflow + tx_full).
  - Status read again returns 8'h02.
  - Then `tx_ready`=1 → `tx_data` sequence 0x01..0x08.
- `rx_valid` with 0x41, 0x42, then hold `ram_addr`=IO_BASE for 4 cycles → `ram_loaded_data`=0x41 and only one pop. Change the address away and back → 0x42. A third access → 0x00.
- TX FIFO full plus a write on the same edge as `tx_ready`=1 → no overflow, count stays 8. Verify pointer wrap over 20 push/pop pairs: data order is preserved.
- Assert `rst`=0 asynchronously mid-stream with 3 TX bytes queued → `tx_valid`=0 immediately and status=8'h00 after release.
- With MEM_IO_LOOPBACK_EN: write 0x5A to IO_BASE, wait 2 cycles, read IO_BASE → 0x5A, and `tx_valid` never rises.
